// File: rtl/ff_d_sincrono.sv
// Parameterizable D flip-flop chain with synchronous active-high reset and complementary outputs.
// Define FF_D_SINCRONO_CHECK_EN to compile in a simulation-only consistency checker.
module ff_d_sincrono_stage #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset) q <= RESET_VALUE;
    else       q <= d;
  end
endmodule

module ff_d_sincrono #(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);
  if (WIDTH < 1) begin : g_bad_width
    $error("ff_d_sincrono: WIDTH must be >= 1");
  end
  if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
    $error("ff_d_sincrono: STAGES must be in 1..16");
  end

  logic [STAGES-1:0][WIDTH-1:0] s;

  // Every stage sees the same reset, so one reset edge flushes the whole line.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_head
      ff_d_sincrono_stage #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_st (
        .clk(clk), .reset(reset), .d(data), .q(s[i])
      );
    end else begin : g_body
      ff_d_sincrono_stage #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_st (
        .clk(clk), .reset(reset), .d(s[i-1]), .q(s[i])
      );
    end
  end

  assign q    = s[STAGES-1];
  assign qbar = ~s[STAGES-1];

`ifdef FF_D_SINCRONO_CHECK_EN
  logic chk_armed;
  logic chk_prev_rst;

  // q is sampled before this edge updates it, i.e. it reflects the previous edge.
  always @(posedge clk) begin
    if ($isunknown(reset))
      $error("ff_d_sincrono: reset is X/Z at clock edge");
    if (chk_armed) begin
      if (qbar !== ~q)
        $error("ff_d_sincrono: qbar is not the complement of q");
      if (chk_prev_rst && (q !== RESET_VALUE))
        $error("ff_d_sincrono: q did not take RESET_VALUE after reset");
    end
    chk_prev_rst <= (reset === 1'b1);
    if (reset === 1'b1) chk_armed <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_ff_d_sincrono.sv
// Directed bench for ff_d_sincrono: three configurations checked against an edge-history model.
module tb_ff_d_sincrono;
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       ra, da, qa, qba;
  logic       rb;
  logic [7:0] db, qb, qbb;
  logic       rc, dc, qc, qbc;

  ff_d_sincrono u_a (.clk(clk), .reset(ra), .data(da), .q(qa), .qbar(qba));
  ff_d_sincrono #(.WIDTH(8), .STAGES(3)) u_b (.clk(clk), .reset(rb), .data(db), .q(qb), .qbar(qbb));
  ff_d_sincrono #(.WIDTH(1), .STAGES(1), .RESET_VALUE(1'b1)) u_c (.clk(clk), .reset(rc), .data(dc), .q(qc), .qbar(qbc));

  int tests = 0;
  int fails = 0;

  // Model: per-edge history of sampled data and reset; q after edge k is RESET_VALUE
  // if any reset landed in the last STAGES edges, else the data sampled STAGES-1 edges earlier.
  logic [7:0] hd [3][2048];
  bit         hr [3][2048];
  int         fr [3] = '{-1, -1, -1};
  int         sv [3] = '{1, 3, 1};
  logic [7:0] rv [3] = '{8'h00, 8'h00, 8'h01};
  logic [7:0] mk [3] = '{8'h01, 8'hFF, 8'h01};
  int         ne = 0;

  function automatic logic [7:0] expq(input int i, input int k);
    for (int j = k - sv[i] + 1; j <= k; j++)
      if (j >= 0 && hr[i][j]) return rv[i];
    return hd[i][k - sv[i] + 1];
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    hd[0][ne] = {7'b0, da}; hr[0][ne] = ra;
    hd[1][ne] = db;         hr[1][ne] = rb;
    hd[2][ne] = {7'b0, dc}; hr[2][ne] = rc;
    for (int i = 0; i < 3; i++)
      if (hr[i][ne] && fr[i] < 0) fr[i] = ne;
    ne++;
    #3;
  endtask

  logic [7:0] qv [3], qbv [3];
  always_comb begin
    qv[0] = {7'b0, qa}; qbv[0] = {7'b0, qba};
    qv[1] = qb;         qbv[1] = qbb;
    qv[2] = {7'b0, qc}; qbv[2] = {7'b0, qbc};
  end

  always @(negedge clk) begin
    if (ne > 0) begin
      for (int i = 0; i < 3; i++) begin
        if (fr[i] >= 0) begin
          check($sformatf("cmp_q[%0d]@e%0d", i, ne - 1), qv[i], expq(i, ne - 1));
          check($sformatf("cmp_qbar[%0d]@e%0d", i, ne - 1), qbv[i], ~expq(i, ne - 1) & mk[i]);
        end
      end
    end
  end

  initial begin
    ra = 1'b1; da = 1'b1; rb = 1'b1; db = 8'h77; rc = 1'b1; dc = 1'b0;
    #3;
    tick(); // E0: reset everywhere
    check("rst_a_q", {7'b0, qa}, 8'h00);  check("rst_a_qbar", {7'b0, qba}, 8'h01);
    check("rst_b_q", qb, 8'h00);          check("rst_b_qbar", qbb, 8'hFF);
    check("rst_c_q", {7'b0, qc}, 8'h01);  check("rst_c_qbar", {7'b0, qbc}, 8'h00);

    ra = 1'b0; da = 1'b1; rb = 1'b0; db = 8'hA5; rc = 1'b0; dc = 1'b0;
    tick(); // E1
    check("cap1_a_q", {7'b0, qa}, 8'h01); check("cap1_a_qbar", {7'b0, qba}, 8'h00);
    check("c_rel_q", {7'b0, qc}, 8'h00);
    check("b_fill1", qb, 8'h00);

    da = 1'b0; db = 8'h3C; dc = 1'b1;
    tick(); // E2
    check("cap0_a_q", {7'b0, qa}, 8'h00); check("cap0_a_qbar", {7'b0, qba}, 8'h01);
    check("b_fill2", qb, 8'h00);

    da = 1'b1; db = 8'hFF; dc = 1'b0;
    tick(); // E3
    check("b_a5_q", qb, 8'hA5); check("b_a5_qbar", qbb, 8'h5A);
    #4;
    ra = 1'b1; da = 1'b1; rc = 1'b1;
    #2;
    check("a_rst_midcycle_hold", {7'b0, qa}, 8'h01);
    db = 8'h11;
    tick(); // E4
    check("a_rst_edge_q", {7'b0, qa}, 8'h00); check("a_rst_edge_qbar", {7'b0, qba}, 8'h01);
    check("b_3c_q", qb, 8'h3C); check("b_3c_qbar", qbb, 8'hC3);
    check("c_rstval_q", {7'b0, qc}, 8'h01); check("c_rstval_qbar", {7'b0, qbc}, 8'h00);

    ra = 1'b0; da = 1'b1; db = 8'h22; rc = 1'b0; dc = 1'b0;
    tick(); // E5
    check("a_release_q", {7'b0, qa}, 8'h01);
    check("b_ff_q", qb, 8'hFF); check("b_ff_qbar", qbb, 8'h00);

    // glitches on a between edges; b reset raised mid-cycle
    rb = 1'b1; db = 8'h44;
    da = 1'b0; #2 ra = 1'b1; #2 ra = 1'b0; #2 da = 1'b1;
    #4 da = 1'b0; #2 ra = 1'b1; #2 ra = 1'b0; #2 da = 1'b1;
    check("a_glitch_hold", {7'b0, qa}, 8'h01);
    check("b_rst_midcycle_hold", qb, 8'hFF);
    tick(); // E6
    check("a_glitch_after", {7'b0, qa}, 8'h01);
    check("b_midstream_rst", qb, 8'h00);

    rb = 1'b0; db = 8'h55;
    tick(); // E7
    check("b_post_rel1", qb, 8'h00);
    db = 8'h66;
    tick(); // E8
    check("b_post_rel2", qb, 8'h00);
    db = 8'h77;
    tick(); // E9
    check("b_post_rel3", qb, 8'h55);
    db = 8'h88;
    tick(); // E10
    check("b_post_rel4", qb, 8'h66);

    for (int n = 0; n < 60; n++) begin
      ra = ($urandom_range(0, 7) == 0); da = 1'($urandom);
      rb = ($urandom_range(0, 7) == 0); db = 8'($urandom);
      rc = ($urandom_range(0, 7) == 0); dc = 1'($urandom);
      tick();
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
